// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command path: FSM states, error codes,
// protocol byte constants and a small elaboration-time helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_ACK,
      ST_RESP
   } ps2State_e;

   localparam logic [1:0] ERR_NO_ACK       = 2'd0;
   localparam logic [1:0] ERR_BIT_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_RESP_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_BAD_RESP     = 2'd3;

   localparam logic [7:0] PS2_ACK_BYTE  = 8'hFA;
   localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

   // Largest of three cycle counts, used to size the shared timeout counter.
   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Brings the raw PS/2 bus lines into the clk domain and turns the device
// clock into a clean, registered falling-edge pulse. A level change is only
// accepted after FILTER_LEN consecutive samples of the new level, so short
// glitches never produce an edge.
module ps2_edge_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2clk_i,
   input  logic ps2data_i,
   output logic data_sync_o,
   output logic fall_pulse_o
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clkSync_q;
   logic [1:0]    dataSync_q;
   logic          level_q;
   logic [CW-1:0] cnt_q;
   logic          fall_q;

   // Two-flop synchronizers for both bus lines; idle bus level is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         clkSync_q  <= 2'b11;
         dataSync_q <= 2'b11;
      end else begin
         clkSync_q  <= {clkSync_q[0], ps2clk_i};
         dataSync_q <= {dataSync_q[0], ps2data_i};
      end
   end

   // Accept a new clock level after FILTER_LEN equal samples; flag high-to-low.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b1;
         cnt_q   <= '0;
         fall_q  <= 1'b0;
      end else begin
         fall_q <= 1'b0;
         if (clkSync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            level_q <= clkSync_q[1];
            cnt_q   <= '0;
            fall_q  <= level_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign data_sync_o  = dataSync_q[1];
   assign fall_pulse_o = fall_q;

endmodule

// File: rtl/ps2_host_cmd.sv
// Host-to-device PS/2 command sequencer. Takes one command byte, inhibits the
// bus, shifts out start/data/parity/stop on the device's clock, checks the
// device ACK bit and then waits for the 0xFA acknowledge byte coming back
// through the scancode receiver, which is disabled while we own the bus.
module ps2_host_cmd
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int FILTER_LEN     = 8,
   parameter int BIT_TIMEOUT    = 65536,
   parameter int RESP_TIMEOUT   = 1048576
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       ps2clk_ext,
   input  logic       ps2data_ext,
   output logic       ps2clk_oe,
   output logic       ps2data_oe,
   output logic       enable_rcv,
   input  logic       rx_strobe,
   input  logic [7:0] rx_scancode,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   localparam int TMO_MAX = maxOf3(INHIBIT_CYCLES, BIT_TIMEOUT, RESP_TIMEOUT);
   localparam int TW      = $clog2(TMO_MAX);

   ps2State_e     state_q;
   logic [7:0]    shift_q;
   logic          parity_q;
   logic [3:0]    bitCnt_q;
   logic [TW-1:0] tmo_q;
   logic          clkOe_q;
   logic          dataOe_q;
   logic          enRcv_q;
   logic          busy_q;
   logic          done_q;
   logic          error_q;
   logic [1:0]    errCode_q;

   logic dataSync;
   logic fallPulse;
   logic inhibitLast;
   logic inhibitPreLast;
   logic bitExpired;
   logic respExpired;

   ps2_edge_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) uEdgeFilter (
      .clk         (clk),
      .rst         (rst),
      .ps2clk_i    (ps2clk_ext),
      .ps2data_i   (ps2data_ext),
      .data_sync_o (dataSync),
      .fall_pulse_o(fallPulse)
   );

   assign inhibitLast    = (tmo_q == TW'(INHIBIT_CYCLES - 1));
   assign inhibitPreLast = (tmo_q == TW'(INHIBIT_CYCLES - 2));
   assign bitExpired     = (tmo_q == TW'(BIT_TIMEOUT - 1));
   assign respExpired    = (tmo_q == TW'(RESP_TIMEOUT - 1));

   // Command sequencer: every bus-facing output is a register so the
   // open-drain enables never glitch. Each device clock fall advances one bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bitCnt_q  <= '0;
         tmo_q     <= '0;
         clkOe_q   <= 1'b0;
         dataOe_q  <= 1'b0;
         enRcv_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         errCode_q <= ERR_NO_ACK;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  shift_q  <= cmd_data;
                  parity_q <= ~^cmd_data;
                  bitCnt_q <= '0;
                  tmo_q    <= '0;
                  busy_q   <= 1'b1;
                  enRcv_q  <= 1'b0;
                  clkOe_q  <= 1'b1;
                  state_q  <= ST_INHIBIT;
               end
            end

            ST_INHIBIT: begin
               if (inhibitLast) begin
                  clkOe_q  <= 1'b0;
                  dataOe_q <= 1'b1;
                  tmo_q    <= '0;
                  state_q  <= ST_START;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
                  if (inhibitPreLast) begin
                     dataOe_q <= 1'b1;
                  end
               end
            end

            ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
               if (fallPulse) begin
                  tmo_q <= '0;
                  case (state_q)
                     ST_START: begin
                        dataOe_q <= ~shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                        bitCnt_q <= 4'd1;
                        state_q  <= ST_DATA;
                     end
                     ST_DATA: begin
                        if (bitCnt_q == 4'd8) begin
                           dataOe_q <= ~parity_q;
                           state_q  <= ST_PARITY;
                        end else begin
                           dataOe_q <= ~shift_q[0];
                           shift_q  <= {1'b0, shift_q[7:1]};
                           bitCnt_q <= bitCnt_q + 4'd1;
                        end
                     end
                     ST_PARITY: begin
                        dataOe_q <= 1'b0;
                        state_q  <= ST_STOP;
                     end
                     ST_STOP: begin
                        state_q <= ST_ACK;
                     end
                     ST_ACK: begin
                        enRcv_q <= 1'b1;
                        if (!dataSync) begin
                           state_q <= ST_RESP;
                        end else begin
                           error_q   <= 1'b1;
                           errCode_q <= ERR_NO_ACK;
                           busy_q    <= 1'b0;
                           clkOe_q   <= 1'b0;
                           dataOe_q  <= 1'b0;
                           state_q   <= ST_IDLE;
                        end
                     end
                     default: begin
                     end
                  endcase
               end else if (bitExpired) begin
                  error_q   <= 1'b1;
                  errCode_q <= ERR_BIT_TIMEOUT;
                  busy_q    <= 1'b0;
                  enRcv_q   <= 1'b1;
                  clkOe_q   <= 1'b0;
                  dataOe_q  <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            ST_RESP: begin
               if (rx_strobe) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                  if (rx_scancode == PS2_ACK_BYTE) begin
                     done_q <= 1'b1;
                  end else begin
                     error_q   <= 1'b1;
                     errCode_q <= ERR_BAD_RESP;
                  end
               end else if (respExpired) begin
                  error_q   <= 1'b1;
                  errCode_q <= ERR_RESP_TIMEOUT;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE);
   assign ps2clk_oe  = clkOe_q;
   assign ps2data_oe = dataOe_q;
   assign enable_rcv = enRcv_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign err_code   = errCode_q;

endmodule

// File: tb/tb_ps2_host_cmd.sv
// Bench for ps2_host_cmd: a PS/2 device model clocks frames out of the host,
// checks every bus bit, and a scoreboard monitor matches each done/error pulse
// against the outcome queued when the command was issued.
module tb_ps2_host_cmd;
   import ps2_pkg::*;

   localparam int INH = 20;
   localparam int FL  = 8;
   localparam int BT  = 200;
   localparam int RT  = 500;
   localparam int H   = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       ps2clk_ext;
   logic       ps2data_ext;
   logic       ps2clk_oe;
   logic       ps2data_oe;
   logic       enable_rcv;
   logic       rx_strobe = 1'b0;
   logic [7:0] rx_scancode = 8'h00;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   logic devClk  = 1'b1;
   logic devData = 1'b1;

   typedef struct {
      bit         isErr;
      logic [1:0] code;
   } expEvt_t;

   expEvt_t expQ[$];
   int nChecks = 0;
   int nFails  = 0;

   assign ps2clk_ext  = devClk & ~ps2clk_oe;
   assign ps2data_ext = devData & ~ps2data_oe;

   ps2_host_cmd #(
      .INHIBIT_CYCLES(INH),
      .FILTER_LEN    (FL),
      .BIT_TIMEOUT   (BT),
      .RESP_TIMEOUT  (RT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_data   (cmd_data),
      .cmd_ready  (cmd_ready),
      .ps2clk_ext (ps2clk_ext),
      .ps2data_ext(ps2data_ext),
      .ps2clk_oe  (ps2clk_oe),
      .ps2data_oe (ps2data_oe),
      .enable_rcv (enable_rcv),
      .rx_strobe  (rx_strobe),
      .rx_scancode(rx_scancode),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer a byte, keep cmd_valid up with different data while busy, and
   // measure the inhibit window and the start bit.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("cmdReady", cmd_ready, 1);
      stepCycles(1);
      cmd_data = ~b;
      n = 0;
      @(negedge clk);
      checkOutput("readyWhileBusy", cmd_ready, 0);
      checkOutput("rcvOffWhileBusy", enable_rcv, 0);
      while (ps2clk_oe && n < 1000) begin
         n++;
         if (n == 5) begin
            cmd_valid = 1'b0;
            cmd_data  = 8'h00;
         end
         @(negedge clk);
      end
      checkOutput("inhibitLen", n, INH);
      checkOutput("startBit", ps2data_ext, 0);
      checkOutput("busyStart", busy, 1);
   endtask

   // Device model: generates nEdges falling edges and checks the host's bits.
   task automatic runDevice(input logic [7:0] b, input logic par, input int nEdges,
                            input bit ackLow, input bit glitch, input int resetEdge);
      logic expBit;
      for (int i = 1; i <= nEdges; i++) begin
         if (glitch && i >= 2 && i <= 9) begin
            stepCycles(14);
            devClk = 1'b0;
            stepCycles(3);
            devClk = 1'b1;
            stepCycles(H - 17);
         end else begin
            stepCycles(H);
         end
         devClk = 1'b0;
         if (i == nEdges && nEdges < 12) begin
            repeat (2 + FL + BT) @(posedge clk);
            @(negedge clk);
            checkOutput("bitTmoEarly", error, 0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("bitTmoExact", error, 1);
            devClk = 1'b1;
            return;
         end
         stepCycles(H - 1);
         @(negedge clk);
         if (i <= 8) expBit = b[i-1];
         else if (i == 9) expBit = par;
         else expBit = 1'b1;
         if (i <= 11) begin
            checkOutput($sformatf("bit%0d", i), ps2data_ext, expBit);
            checkOutput("busyFrame", busy, 1);
         end
         if (i == resetEdge) begin
            expBit = ~b[i-1];
            checkOutput("oeBeforeRst", ps2data_oe, expBit);
            stepCycles(1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstClkOe", ps2clk_oe, 0);
            checkOutput("rstDataOe", ps2data_oe, 0);
            checkOutput("rstReady", cmd_ready, 1);
            checkOutput("rstBusy", busy, 0);
            rst    = 1'b0;
            devClk = 1'b1;
            return;
         end
         if (i == 11 && ackLow) devData = 1'b0;
         if (i == 12) devData = 1'b1;
         stepCycles(1);
         devClk = 1'b1;
      end
   endtask

   task automatic respond(input logic [7:0] v);
      stepCycles(20);
      rx_scancode = v;
      rx_strobe   = 1'b1;
      stepCycles(1);
      rx_strobe   = 1'b0;
      rx_scancode = 8'h00;
   endtask

   task automatic waitIdle(input int maxCycles);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < maxCycles) begin
         n++;
         @(negedge clk);
      end
      checkOutput("idleReached", busy, 0);
   endtask

   // mode: 0 full frame + response, 1 no ACK, 2 clock stops after bit 3,
   //       3 no response, 4 reset during data
   task automatic runCommand(input logic [7:0] b, input logic par, input int mode,
                             input logic [7:0] resp, input bit glitch);
      expEvt_t e;
      case (mode)
         0: begin e.isErr = (resp != 8'hFA); e.code = 2'd3; end
         1: begin e.isErr = 1'b1; e.code = 2'd0; end
         2: begin e.isErr = 1'b1; e.code = 2'd1; end
         3: begin e.isErr = 1'b1; e.code = 2'd2; end
         default: begin e.isErr = 1'b0; e.code = 2'd0; end
      endcase
      if (mode != 4) expQ.push_back(e);
      applyStimulus(b);
      runDevice(b, par, (mode == 2) ? 4 : 12, (mode != 1), glitch, (mode == 4) ? 3 : 0);
      if (mode == 0) respond(resp);
      if (mode != 4) waitIdle(3 * RT);
      stepCycles(40);
   endtask

   // Scoreboard monitor: every done/error pulse must match the oldest expectation.
   always @(negedge clk) begin
      expEvt_t e;
      if (done || error) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedEvent", {done, error}, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("evtKind", {done, error}, {~e.isErr, e.isErr});
            if (e.isErr) checkOutput("errCode", err_code, e.code);
            checkOutput("evtBusy", busy, 0);
            checkOutput("evtClkOe", ps2clk_oe, 0);
            checkOutput("evtDataOe", ps2data_oe, 0);
            checkOutput("evtRcv", enable_rcv, 1);
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: simulation did not finish, %0d checks", nChecks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stepCycles(3);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstCmdReady", cmd_ready, 1);
      checkOutput("rstClkOe0", ps2clk_oe, 0);
      checkOutput("rstDataOe0", ps2data_oe, 0);
      checkOutput("rstEnRcv", enable_rcv, 1);
      checkOutput("rstBusy0", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstError", error, 0);
      checkOutput("rstErrCode", err_code, 0);

      // A receiver byte while idle must not complete anything.
      stepCycles(1);
      rx_scancode = 8'hFA;
      rx_strobe   = 1'b1;
      stepCycles(1);
      rx_strobe   = 1'b0;
      @(negedge clk);
      checkOutput("idleStrobeDone", done, 0);
      stepCycles(5);

      runCommand(PS2_CMD_LEDS, 1'b1, 0, 8'hFA, 1'b0);
      runCommand(8'h00, 1'b1, 0, 8'hFA, 1'b0);
      runCommand(8'h01, 1'b0, 0, 8'hFA, 1'b0);
      runCommand(PS2_CMD_RESET, 1'b1, 0, 8'hFA, 1'b1);
      runCommand(8'hF4, 1'b0, 1, 8'h00, 1'b0);
      runCommand(8'hF2, 1'b0, 2, 8'h00, 1'b0);
      runCommand(8'hEE, 1'b1, 0, 8'hFE, 1'b0);
      runCommand(8'hF5, 1'b1, 3, 8'h00, 1'b0);
      runCommand(8'hA0, 1'b1, 4, 8'h00, 1'b0);
      runCommand(PS2_CMD_LEDS, 1'b1, 0, 8'hFA, 1'b1);

      stepCycles(50);
      checkOutput("scoreboardDrained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
